// File: rtl/ma_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ma_ctrl_pkg
// Shared types and helpers for the moving-average sequencing controller.
//   state_t           : controller sequence FLUSH -> WAIT_READY -> FILL -> RUN
//   clamp_length()    : maps a requested window length of 0 to 1
//   clamp_decimation(): maps a requested decimation of 0 to 1 (0 and 1 both
//                       mean "emit every settled sum")
// ---------------------------------------------------------------------------
package ma_ctrl_pkg;

    typedef enum logic [1:0] {
        FLUSH      = 2'd0,
        WAIT_READY = 2'd1,
        FILL       = 2'd2,
        RUN        = 2'd3
    } state_t;

    function automatic int unsigned clamp_length(input int unsigned length);
        return (length == 32'd0) ? 32'd1 : length;
    endfunction

    function automatic int unsigned clamp_decimation(input int unsigned decimation);
        return (decimation == 32'd0) ? 32'd1 : decimation;
    endfunction

endpackage

// File: rtl/moving_average_ctrl.sv
// ---------------------------------------------------------------------------
// moving_average_ctrl
// Sequencing controller wrapped around the lock-in moving-average datapath.
// Owns the window length, flushes the averager whenever the length changes,
// waits for the averager to report ready, suppresses sums until the window
// is full, then decimates the settled sum stream.
//
// Ports
//   clock, reset        : system clock, synchronous active-high reset
//   cfg_length          : requested window length (0 treated as 1)
//   cfg_decimation      : output decimation (0 and 1 mean every sum)
//   cfg_valid           : strobe, latch cfg_* and restart the sequence
//   busy                : high in every state except RUN
//   data_in/_valid      : upstream sample stream
//   ma_reset            : reset to the averager
//   ma_length           : applied window length
//   ma_data_in/_valid   : sample stream forwarded to the averager
//   ma_ready            : averager shift register ready
//   ma_data_out/_valid  : averager running sum
//   data_out/_valid     : decimated, fully-settled sum
//   dropped_count       : saturating count of discarded upstream samples
// ---------------------------------------------------------------------------
module moving_average_ctrl
    import ma_ctrl_pkg::*;
#(
    parameter int MAX_DECIMATION     = 1024,
    parameter int MAX_OUT_DECIMATION = 4096,
    parameter int DATA_BITS          = 64,
    parameter int FLUSH_CYCLES       = 2,
    localparam int LW = $clog2(MAX_DECIMATION),
    localparam int DW = $clog2(MAX_OUT_DECIMATION)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [LW-1:0]        cfg_length,
    input  logic [DW-1:0]        cfg_decimation,
    input  logic                 cfg_valid,
    output logic                 busy,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_in_valid,
    output logic                 ma_reset,
    output logic [LW-1:0]        ma_length,
    output logic [DATA_BITS-1:0] ma_data_in,
    output logic                 ma_data_in_valid,
    input  logic                 ma_ready,
    input  logic [DATA_BITS-1:0] ma_data_out,
    input  logic                 ma_data_out_valid,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    output logic [15:0]          dropped_count
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    state_t        state;
    logic [FW-1:0] flush_cnt;
    logic [LW:0]   fill_cnt;      // one extra bit so the largest length compares cleanly
    logic [DW-1:0] decimation;
    logic [DW-1:0] dec_cnt;
    logic          accepting;
    logic          sample_dropped;

    // A sample arriving with cfg_valid belongs to the old configuration and
    // would corrupt the freshly flushed window, so it is discarded.
    assign accepting        = (state == FILL) || (state == RUN);
    assign ma_data_in_valid = data_in_valid && accepting && !cfg_valid;
    assign sample_dropped   = data_in_valid && (!accepting || cfg_valid);
    assign ma_data_in       = data_in;
    assign ma_reset         = reset || (state == FLUSH);
    assign busy             = (state != RUN);

    // NOTE: every register here, data path included, is given a reset value so
    // downstream never observes an X sum or a stale strobe after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= FLUSH;
            flush_cnt      <= '0;
            fill_cnt       <= '0;
            dec_cnt        <= '0;
            ma_length      <= LW'(1);
            decimation     <= DW'(1);
            data_out       <= '0;
            data_out_valid <= 1'b0;
            dropped_count  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge register values regardless of statement order.
            if (sample_dropped && (dropped_count != 16'hFFFF))
                dropped_count <= dropped_count + 16'd1;

            data_out_valid <= 1'b0;

            if (cfg_valid) begin
                // Length updates on the same edge as FLUSH entry so the
                // averager never runs a length it was not flushed for.
                ma_length  <= LW'(clamp_length(32'(cfg_length)));
                decimation <= DW'(clamp_decimation(32'(cfg_decimation)));
                state      <= FLUSH;
                flush_cnt  <= '0;
                fill_cnt   <= '0;
                dec_cnt    <= '0;
            end else begin
                unique case (state)
                    FLUSH: begin
                        if (flush_cnt == FLUSH_LAST)
                            state <= WAIT_READY;
                        else
                            flush_cnt <= flush_cnt + FW'(1);
                    end
                    WAIT_READY: begin
                        fill_cnt <= '0;
                        if (ma_ready)
                            state <= FILL;
                    end
                    FILL: begin
                        // The sum that completes the window is swallowed; the
                        // first forwarded sum is the one after it.
                        if (ma_data_out_valid) begin
                            fill_cnt <= fill_cnt + (LW+1)'(1);
                            if ((fill_cnt + (LW+1)'(1)) == {1'b0, ma_length}) begin
                                state   <= RUN;
                                dec_cnt <= '0;
                            end
                        end
                    end
                    RUN: begin
                        if (ma_data_out_valid) begin
                            if (dec_cnt == (decimation - DW'(1))) begin
                                data_out       <= ma_data_out;
                                data_out_valid <= 1'b1;
                                dec_cnt        <= '0;
                            end else begin
                                dec_cnt <= dec_cnt + DW'(1);
                            end
                        end
                    end
                    default: state <= FLUSH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_moving_average_ctrl.sv
// ---------------------------------------------------------------------------
// tb_moving_average_ctrl
// Scoreboard bench for moving_average_ctrl. A behavioural averager (history
// queue, 1-cycle sum latency, ready a few cycles after its reset falls) sits
// on the ma_* side. Expected data_out values are computed at stimulus time
// from the window/fill/decimation rules and queued; a negedge monitor pops
// and compares whenever data_out_valid is seen.
// ---------------------------------------------------------------------------
module tb_moving_average_ctrl;

    localparam int LW          = 10;
    localparam int DW          = 12;
    localparam int DB          = 64;
    localparam int READY_DELAY = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [LW-1:0] cfg_length;
    logic [DW-1:0] cfg_decimation;
    logic          cfg_valid;
    logic          busy;
    logic [DB-1:0] data_in;
    logic          data_in_valid;
    logic          ma_reset;
    logic [LW-1:0] ma_length;
    logic [DB-1:0] ma_data_in;
    logic          ma_data_in_valid;
    logic          ma_ready;
    logic [DB-1:0] ma_data_out;
    logic          ma_data_out_valid;
    logic [DB-1:0] data_out;
    logic          data_out_valid;
    logic [15:0]   dropped_count;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            exp_dropped = 0;
    logic [DB-1:0] exp_q [$];
    logic          hold_not_ready = 1'b0;

    moving_average_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .cfg_length        (cfg_length),
        .cfg_decimation    (cfg_decimation),
        .cfg_valid         (cfg_valid),
        .busy              (busy),
        .data_in           (data_in),
        .data_in_valid     (data_in_valid),
        .ma_reset          (ma_reset),
        .ma_length         (ma_length),
        .ma_data_in        (ma_data_in),
        .ma_data_in_valid  (ma_data_in_valid),
        .ma_ready          (ma_ready),
        .ma_data_out       (ma_data_out),
        .ma_data_out_valid (ma_data_out_valid),
        .data_out          (data_out),
        .data_out_valid    (data_out_valid),
        .dropped_count     (dropped_count)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural averager ----------------
    logic [DB-1:0] hist [$];
    int            rdy_cnt = 0;

    function automatic logic [DB-1:0] window_sum(input int len);
        logic [DB-1:0] acc = '0;
        for (int j = 0; j < hist.size() && j < len; j++) acc += hist[j];
        return acc;
    endfunction

    always @(posedge clock) begin
        if (ma_reset) begin
            hist.delete();
            rdy_cnt           <= 0;
            ma_ready          <= 1'b0;
            ma_data_out_valid <= 1'b0;
            ma_data_out       <= '0;
        end else begin
            ma_ready          <= (rdy_cnt == READY_DELAY) && !hold_not_ready;
            rdy_cnt           <= (rdy_cnt < READY_DELAY) ? rdy_cnt + 1 : rdy_cnt;
            ma_data_out_valid <= ma_data_in_valid;
            if (ma_data_in_valid) begin
                hist.push_front(ma_data_in);
                if (hist.size() > 1024) void'(hist.pop_back());
                ma_data_out <= window_sum(int'(ma_length));
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (data_out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %0h expected no output", data_out);
            end else begin
                check("data_out", data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    function automatic int bump(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic drive_cycle(input logic v, input logic [DB-1:0] d, input logic cv, input logic rst);
        data_in_valid = v;
        data_in       = d;
        cfg_valid     = cv;
        reset         = rst;
        @(posedge clock);
        #1;
        data_in_valid = 1'b0;
        cfg_valid     = 1'b0;
        reset         = 1'b0;
    endtask

    // Samples go to an averager already in FILL. Sum k covers samples
    // k-L+1..k; sums 0..L-1 fill the window, and of the rest every D-th is
    // emitted, starting with sum L+D-1.
    task automatic drive_samples(input int L, input int D, input int n, input int mode, input bit gaps);
        logic [DB-1:0] s [$];
        logic [DB-1:0] v;
        logic [DB-1:0] acc;
        for (int k = 0; k < n; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) drive_cycle(1'b0, '0, 1'b0, 1'b0);
            case (mode)
                0:       v = 64'd1;
                1:       v = 64'(k + 1);
                default: v = {$urandom, $urandom};
            endcase
            s.push_back(v);
            if (k >= L && ((k - L) % D) == D - 1) begin
                acc = '0;
                for (int j = k; j >= 0 && j > k - L; j--) acc += s[j];
                exp_q.push_back(acc);
            end
            drive_cycle(1'b1, v, 1'b0, 1'b0);
        end
        repeat (6) drive_cycle(1'b0, '0, 1'b0, 1'b0);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("dropped_count", 64'(dropped_count), 64'(exp_dropped));
    endtask

    // pre: 0 plain cfg, 1 sum in flight at cfg, 2 cfg restarting mid-FLUSH,
    //      3 cfg coinciding with reset (ignored, length/decimation = 1)
    task automatic run_phase(input int len, input int dec, input int n, input int mode,
                             input bit gaps, input int pre);
        int L;
        int D;
        bit b;
        L = (len == 0) ? 1 : len;
        D = (dec <= 1) ? 1 : dec;
        if (pre == 1) drive_cycle(1'b1, 64'hDEAD_BEEF, 1'b0, 1'b0);
        if (pre == 2) begin
            cfg_length     = LW'(len + 5);
            cfg_decimation = DW'(dec + 4);
            drive_cycle(1'b0, '0, 1'b1, 1'b0);
            drive_cycle(1'b0, '0, 1'b0, 1'b0);
        end
        cfg_length     = LW'(len);
        cfg_decimation = DW'(dec);
        if (pre == 3) begin
            L = 1;
            D = 1;
            drive_cycle(1'b1, 64'd7, 1'b1, 1'b1);
            exp_dropped = 0;
        end else begin
            drive_cycle(1'b1, 64'd7, 1'b1, 1'b0);
            exp_dropped = bump(exp_dropped);
        end
        check("busy_after_cfg", 64'(busy), 64'd1);
        check("no_valid_after_cfg", 64'(data_out_valid), 64'd0);
        check("ma_length", 64'(ma_length), 64'(L));
        check("ma_reset_flush0", 64'(ma_reset), 64'd1);
        b = 1'($urandom_range(0, 1));
        if (b) exp_dropped = bump(exp_dropped);
        drive_cycle(b, 64'($urandom), 1'b0, 1'b0);
        check("ma_reset_flush1", 64'(ma_reset), 64'd1);
        b = 1'($urandom_range(0, 1));
        if (b) exp_dropped = bump(exp_dropped);
        drive_cycle(b, 64'($urandom), 1'b0, 1'b0);
        check("ma_reset_released", 64'(ma_reset), 64'd0);
        b = 1'($urandom_range(0, 1));
        if (b) exp_dropped = bump(exp_dropped);
        drive_cycle(b, 64'($urandom), 1'b0, 1'b0);
        repeat (7) drive_cycle(1'b0, '0, 1'b0, 1'b0);
        check("busy_in_fill", 64'(busy), 64'd1);
        drive_samples(L, D, n, mode, gaps);
        check("busy_in_run", 64'(busy), 64'd0);
    endtask

    initial begin
        reset          = 1'b1;
        cfg_valid      = 1'b0;
        cfg_length     = '0;
        cfg_decimation = '0;
        data_in_valid  = 1'b0;
        data_in        = '0;
        repeat (3) drive_cycle(1'($urandom_range(0, 1)), 64'($urandom), 1'b0, 1'b1);
        check("rst_data_out_valid", 64'(data_out_valid), 64'd0);
        check("rst_data_out", data_out, 64'd0);
        check("rst_dropped", 64'(dropped_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_ma_reset", 64'(ma_reset), 64'd1);
        check("rst_ma_length", 64'(ma_length), 64'd1);

        run_phase(8, 3, 40, 1, 1'b0, 0);    // window 8, every 3rd sum, ramp
        run_phase(4, 1, 20, 0, 1'b0, 0);    // window 4, constant 1 -> 4
        run_phase(16, 1, 50, 2, 1'b1, 1);   // 4 -> 16 with a sum in flight
        run_phase(0, 0, 20, 2, 1'b1, 0);    // length 0 clamps to 1
        run_phase(5, 2, 30, 2, 1'b1, 2);    // restart mid-FLUSH
        run_phase(77, 3, 15, 2, 1'b0, 3);   // cfg discarded under reset

        // Averager held not-ready: everything is dropped until saturation.
        hold_not_ready = 1'b1;
        cfg_length     = LW'(4);
        cfg_decimation = DW'(1);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        repeat (37) begin
            exp_dropped = bump(exp_dropped);
            drive_cycle(1'b1, 64'($urandom), 1'b0, 1'b0);
        end
        check("dropped_partial", 64'(dropped_count), 64'(exp_dropped));
        check("busy_held", 64'(busy), 64'd1);
        repeat (65535) begin
            exp_dropped = bump(exp_dropped);
            drive_cycle(1'b1, 64'($urandom), 1'b0, 1'b0);
        end
        check("dropped_saturated", 64'(dropped_count), 64'hFFFF);
        hold_not_ready = 1'b0;
        repeat (4) drive_cycle(1'b0, '0, 1'b0, 1'b0);
        drive_samples(4, 1, 12, 2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
